// File: rtl/regfile_2w2r_sb_if.sv
// Operand read, writeback and reservation signals of the two-write/two-read register file.
interface regfile_2w2r_sb_if #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 5
);
  logic [ADDR_BITS-1:0] RA;
  logic [ADDR_BITS-1:0] RB;
  logic [WIDTH-1:0]     BusA;
  logic [WIDTH-1:0]     BusB;
  logic                 BusyA;
  logic                 BusyB;
  logic [ADDR_BITS-1:0] RW0;
  logic [WIDTH-1:0]     BusW0;
  logic                 RegWr0;
  logic [ADDR_BITS-1:0] RW1;
  logic [WIDTH-1:0]     BusW1;
  logic                 RegWr1;
  logic                 RsvEn;
  logic [ADDR_BITS-1:0] RsvAddr;

  modport master (
    output RA, RB, RW0, BusW0, RegWr0, RW1, BusW1, RegWr1, RsvEn, RsvAddr,
    input  BusA, BusB, BusyA, BusyB
  );

  modport slave (
    input  RA, RB, RW0, BusW0, RegWr0, RW1, BusW1, RegWr1, RsvEn, RsvAddr,
    output BusA, BusB, BusyA, BusyB
  );
endinterface

// File: rtl/regfile_2w2r_sb.sv
// Decode-stage register file: two prioritised write ports, two combinational read ports,
// optional same-cycle bypass, optional hardwired-zero register and a per-register busy scoreboard.
module regfile_2w2r_sb #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 5,
  parameter int ZERO_REG  = 31,
  parameter int BYPASS    = 1
) (
  input logic               Clk,
  input logic               ResetN,
  regfile_2w2r_sb_if.slave  rf
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;

  logic             w_wr0;
  logic             w_wr1;
  logic             w_rsv;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [WIDTH-1:0] w_bus_a;
  logic [WIDTH-1:0] w_bus_b;
  logic             w_busy_a;
  logic             w_busy_b;

  // An out-of-range ZERO_REG never matches, which disables the zero register.
  function automatic logic f_is_zero(input logic [ADDR_BITS-1:0] a);
    return (ZERO_REG < DEPTH) && (int'(a) == ZERO_REG);
  endfunction

  function automatic logic [WIDTH-1:0] f_read(input logic [ADDR_BITS-1:0] a);
    logic [WIDTH-1:0] d;
    d = r_mem[a];
    if (f_is_zero(a)) begin
      d = '0;
    end else if (BYPASS != 0) begin
      if (w_wr1 && (rf.RW1 == a)) begin
        d = rf.BusW1;
      end else if (w_wr0 && (rf.RW0 == a)) begin
        d = rf.BusW0;
      end
    end
    return d;
  endfunction

  function automatic logic f_busy(input logic [ADDR_BITS-1:0] a);
    logic b;
    b = r_busy[a];
    if (f_is_zero(a)) begin
      b = 1'b0;
    end else if (BYPASS != 0) begin
      if (((w_wr0 && (rf.RW0 == a)) || (w_wr1 && (rf.RW1 == a))) &&
          !(w_rsv && (rf.RsvAddr == a))) begin
        b = 1'b0;
      end
    end
    return b;
  endfunction

  assign w_wr0 = rf.RegWr0 && !f_is_zero(rf.RW0);
  assign w_wr1 = rf.RegWr1 && !f_is_zero(rf.RW1);
  assign w_rsv = rf.RsvEn  && !f_is_zero(rf.RsvAddr);

  // Reserve is applied last so a new producer wins over a same-cycle writeback.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr0) w_busy_nxt[rf.RW0] = 1'b0;
    if (w_wr1) w_busy_nxt[rf.RW1] = 1'b0;
    if (w_rsv) w_busy_nxt[rf.RsvAddr] = 1'b1;
  end

  always_comb begin
    w_bus_a  = f_read(rf.RA);
    w_bus_b  = f_read(rf.RB);
    w_busy_a = f_busy(rf.RA);
    w_busy_b = f_busy(rf.RB);
  end

  assign rf.BusA  = w_bus_a;
  assign rf.BusB  = w_bus_b;
  assign rf.BusyA = w_busy_a;
  assign rf.BusyB = w_busy_b;

  // Port 1 is written second so it wins a same-address collision.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr0) r_mem[rf.RW0] <= rf.BusW0;
      if (w_wr1) r_mem[rf.RW1] <= rf.BusW1;
      r_busy <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Directed checks of the register file: default instance, a no-bypass instance and a
// 32-bit/16-entry instance with the zero register disabled.
module tb_regfile_2w2r_sb;

  logic Clk;
  logic ResetN;
  int   checks;
  int   failures;

  regfile_2w2r_sb_if #(.WIDTH(64), .ADDR_BITS(5)) if_a ();
  regfile_2w2r_sb_if #(.WIDTH(64), .ADDR_BITS(5)) if_b ();
  regfile_2w2r_sb_if #(.WIDTH(32), .ADDR_BITS(4)) if_c ();

  regfile_2w2r_sb #(.WIDTH(64), .ADDR_BITS(5), .ZERO_REG(31), .BYPASS(1)) u_byp (
    .Clk(Clk), .ResetN(ResetN), .rf(if_a));
  regfile_2w2r_sb #(.WIDTH(64), .ADDR_BITS(5), .ZERO_REG(31), .BYPASS(0)) u_nobyp (
    .Clk(Clk), .ResetN(ResetN), .rf(if_b));
  regfile_2w2r_sb #(.WIDTH(32), .ADDR_BITS(4), .ZERO_REG(16), .BYPASS(1)) u_small (
    .Clk(Clk), .ResetN(ResetN), .rf(if_c));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    if_a.RegWr0 = 0; if_a.RegWr1 = 0; if_a.RsvEn = 0;
    if_b.RegWr0 = 0; if_b.RegWr1 = 0; if_b.RsvEn = 0;
    if_c.RegWr0 = 0; if_c.RegWr1 = 0; if_c.RsvEn = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    ResetN = 0;
    if_a.RA = 0; if_a.RB = 0; if_a.RW0 = 0; if_a.RW1 = 0; if_a.BusW0 = 0; if_a.BusW1 = 0; if_a.RsvAddr = 0;
    if_b.RA = 0; if_b.RB = 0; if_b.RW0 = 0; if_b.RW1 = 0; if_b.BusW0 = 0; if_b.BusW1 = 0; if_b.RsvAddr = 0;
    if_c.RA = 0; if_c.RB = 0; if_c.RW0 = 0; if_c.RW1 = 0; if_c.BusW0 = 0; if_c.BusW1 = 0; if_c.RsvAddr = 0;
    idle();
    tick();
    ResetN = 1;
    if_a.RA = 5; if_a.RB = 5;
    #1;
    chk("reset_busa", if_a.BusA, 64'h0);
    chk("reset_busya", if_a.BusyA, 64'h0);

    // Preload R5 and mark it busy, then reset
    if_a.RW0 = 5; if_a.BusW0 = 64'hDEAD; if_a.RegWr0 = 1;
    tick();
    idle();
    if_a.RsvEn = 1; if_a.RsvAddr = 5;
    tick();
    idle();
    #1;
    chk("preload_r5", if_a.BusA, 64'hDEAD);
    chk("preload_busy5", if_a.BusyA, 64'h1);
    ResetN = 0;
    tick();
    ResetN = 1;
    #1;
    chk("post_reset_r5", if_a.BusA, 64'h0);
    chk("post_reset_busy5", if_a.BusyA, 64'h0);

    // Zero register: write and reserve both dropped
    if_a.RA = 31;
    if_a.RW0 = 31; if_a.BusW0 = '1; if_a.RegWr0 = 1;
    if_a.RsvEn = 1; if_a.RsvAddr = 31;
    #1;
    chk("zero_busa_during", if_a.BusA, 64'h0);
    chk("zero_busya_during", if_a.BusyA, 64'h0);
    tick();
    idle();
    #1;
    chk("zero_busa_after", if_a.BusA, 64'h0);
    chk("zero_busya_after", if_a.BusyA, 64'h0);

    // Collision on R7: port 1 wins, bypass shows port 1 data
    if_a.RA = 7;
    if_a.RW0 = 7; if_a.BusW0 = 64'h11; if_a.RegWr0 = 1;
    if_a.RW1 = 7; if_a.BusW1 = 64'h22; if_a.RegWr1 = 1;
    #1;
    chk("collide_bypass", if_a.BusA, 64'h22);
    tick();
    idle();
    #1;
    chk("collide_stored", if_a.BusA, 64'h22);

    // Port 0 alone bypasses onto read port B
    if_a.RB = 8;
    if_a.RW0 = 8; if_a.BusW0 = 64'h1234_5678_9ABC_DEF0; if_a.RegWr0 = 1;
    #1;
    chk("p0_bypass_b", if_a.BusB, 64'h1234_5678_9ABC_DEF0);
    tick();
    idle();
    #1;
    chk("p0_stored_b", if_a.BusB, 64'h1234_5678_9ABC_DEF0);

    // Scoreboard on R9
    if_a.RA = 9;
    if_a.RsvEn = 1; if_a.RsvAddr = 9;
    #1;
    chk("rsv_no_bypass", if_a.BusyA, 64'h0);
    tick();
    idle();
    #1;
    chk("rsv_n", if_a.BusyA, 64'h1);
    tick();
    tick();
    chk("rsv_n2", if_a.BusyA, 64'h1);
    if_a.RW1 = 9; if_a.BusW1 = 64'h55; if_a.RegWr1 = 1;
    #1;
    chk("wb_busy_bypass", if_a.BusyA, 64'h0);
    chk("wb_data_bypass", if_a.BusA, 64'h55);
    tick();
    idle();
    #1;
    chk("wb_busy_after", if_a.BusyA, 64'h0);
    chk("wb_data_after", if_a.BusA, 64'h55);
    if_a.RsvEn = 1; if_a.RsvAddr = 9;
    if_a.RW0 = 9; if_a.BusW0 = 64'h77; if_a.RegWr0 = 1;
    #1;
    chk("rsv_wr_busy_during", if_a.BusyA, 64'h0);
    chk("rsv_wr_data_during", if_a.BusA, 64'h77);
    tick();
    idle();
    #1;
    chk("rsv_wr_busy_after", if_a.BusyA, 64'h1);
    chk("rsv_wr_data_after", if_a.BusA, 64'h77);
    if_a.RsvEn = 1; if_a.RsvAddr = 9;
    tick();
    idle();
    #1;
    chk("rsv_again_busy", if_a.BusyA, 64'h1);
    if_a.RB = 10;
    if_a.RW1 = 10; if_a.BusW1 = 64'hA; if_a.RegWr1 = 1;
    tick();
    idle();
    #1;
    chk("wr_nonbusy_stays0", if_a.BusyB, 64'h0);

    // Reset mid-operation: R4 busy, write to R4 at the reset edge
    if_a.RsvEn = 1; if_a.RsvAddr = 4;
    tick();
    idle();
    if_a.RA = 4; if_a.RB = 9;
    #1;
    chk("r4_busy_pre", if_a.BusyA, 64'h1);
    if_a.RW0 = 4; if_a.BusW0 = 64'h99; if_a.RegWr0 = 1;
    ResetN = 0;
    tick();
    ResetN = 1;
    idle();
    #1;
    chk("midrst_r4_data", if_a.BusA, 64'h0);
    chk("midrst_r4_busy", if_a.BusyA, 64'h0);
    chk("midrst_r9_data", if_a.BusB, 64'h0);
    chk("midrst_r9_busy", if_a.BusyB, 64'h0);

    // No-bypass instance
    if_b.RB = 3;
    if_b.RW0 = 3; if_b.BusW0 = 64'hABCD; if_b.RegWr0 = 1;
    #1;
    chk("nobyp_old", if_b.BusB, 64'h0);
    tick();
    idle();
    #1;
    chk("nobyp_new", if_b.BusB, 64'hABCD);
    if_b.RA = 2;
    if_b.RsvEn = 1; if_b.RsvAddr = 2;
    tick();
    idle();
    if_b.RW1 = 2; if_b.BusW1 = 64'h5; if_b.RegWr1 = 1;
    #1;
    chk("nobyp_busy_during", if_b.BusyA, 64'h1);
    chk("nobyp_data_during", if_b.BusA, 64'h0);
    tick();
    idle();
    #1;
    chk("nobyp_busy_after", if_b.BusyA, 64'h0);
    chk("nobyp_data_after", if_b.BusA, 64'h5);

    // Small instance, zero register disabled: every entry writable
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) begin
        if_c.RW0 = 4'(i); if_c.BusW0 = 32'hC0DE_0000 + 32'(i); if_c.RegWr0 = 1;
      end else begin
        if_c.RW1 = 4'(i); if_c.BusW1 = 32'hC0DE_0000 + 32'(i); if_c.RegWr1 = 1;
      end
      tick();
      idle();
    end
    for (int i = 0; i < 16; i++) begin
      if_c.RA = 4'(i);
      #1;
      chk($sformatf("small_r%0d", i), 64'(if_c.BusA), 64'hC0DE_0000 + 64'(i));
    end
    if_c.RsvEn = 1; if_c.RsvAddr = 15; if_c.RB = 15;
    tick();
    idle();
    #1;
    chk("small_busy15", if_c.BusyB, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
